ram_sp_arbiter: RTL and testbench
=================================

RAM_SP_ARBITER -- requirements
Module: ram_sp_arbiter

Interface
REQ-001 Parameters, one per line:
  - N_REQ, default 2: number of requesters (2..4).
  - ADDR_W, default 4: RAM address width.
  - DATA_W, default 8: RAM data width.
REQ-002 Ports, one per line:
  - clk  in  1  single clock, all logic on posedge.
  - rst  in  1  reset, synchronous, active-high.
  - req_valid  in  N_REQ  per-requester request valid.
  - req_ready  out  N_REQ  per-requester grant/accept.
  - req_we  in  N_REQ  per-requester write enable (1 = write, 0 = read).
  - req_add  in  N_REQ*ADDR_W  per-requester address, packed, requester i at [i*ADDR_W +: ADDR_W].
  - req_din  in  N_REQ*DATA_W  per-requester write data, packed likewise.
  - rsp_valid  out  N_REQ  one-cycle read-data strobe per requester.
  - rsp_data  out  DATA_W  read data, shared bus, meaningful only while any rsp_valid bit is high.
  - ram_add  out  ADDR_W  to RAM address.
  - ram_din  out  DATA_W  to RAM write data.
  - ram_wr_en  out  1  to RAM write enable.
  - ram_dout  in  DATA_W  from RAM; registered-address read, valid the cycle after the address edge.
  - init_done  out  1  high once the post-reset clear sweep completes.

Function
REQ-003 Two states, INIT and RUN; reset enters INIT.
REQ-004 INIT behaviour:
  - Drive ram_wr_en=1, ram_din=0 and ram_add=sweep counter, starting at 0.
  - Increment the counter once per cycle.
  - After writing address 2^ADDR_W-1, go to RUN on the next edge, with init_done=1 from that edge on.
REQ-005 In INIT, req_ready shall be all-zero.
REQ-006 In RUN, req_ready shall be combinational one-hot (or zero): exactly one bit for the selected valid requester, none when no req_valid is set.
REQ-007 Arbitration shall be round-robin:
  - A priority pointer selects the first valid requester at or after the pointer, wrapping modulo N_REQ.
  - On each accepted request the pointer moves to (granted index + 1) mod N_REQ.
  - The pointer resets to 0.
REQ-008 An accept occurs at a clock edge where req_valid[i] & req_ready[i] = 1. At most one accept per cycle, and a new accept is allowed every cycle (fully pipelined).
REQ-009 In RUN, ram_add, ram_din and ram_wr_en shall be combinational from the granted requester (req_we gated by grant). With no grant, ram_wr_en=0 and ram_add holds the last granted address.
REQ-010 Read latency shall be 2 edges:
  - The read accepted at edge E captures the address in the RAM at E.
  - The controller registers ram_dout into rsp_data at E+1.
  - rsp_valid[i] is high for exactly the cycle after E+1.
REQ-011 Back-to-back reads from any requesters shall produce responses in accept order, one per cycle, with no gaps or drops.
REQ-012 Writes shall produce no response (see REQ-016).
REQ-013 A read from address A accepted the cycle after a write to A shall return the new data (write-first via RAM timing). The controller shall add no forwarding logic.
REQ-014 Requesters may hold or change req_valid freely. A non-granted request shall not be dropped by the controller; it waits while its valid stays high.

Reset
REQ-015 rst high at an edge shall, regardless of state or in-flight reads:
  - Set state=INIT, sweep counter=0, pointer=0, init_done=0, rsp_valid=0, rsp_data=0.
  - Discard pending read responses.
  - Restart the clear sweep from address 0, with req_ready=0 until the sweep completes.

Configuration
REQ-016 Macro RAM_ARB_WR_ACK_EN:
  - Defined: an accepted write also produces rsp_valid[i] with the same 2-edge latency, with rsp_data equal to the written data.
  - Undefined: writes produce no response (REQ-012).

Structure
REQ-017 Shared package ram_arb_pkg shall hold:
  - the state enum (INIT, RUN);
  - default ADDR_W, DATA_W and N_REQ constants;
  - the RAM depth constant 2^ADDR_W.
REQ-018 One sub-module, rr_pick, shall be a combinational round-robin selector: inputs valid vector and pointer, output one-hot grant. The sweep counter, response pipeline and RAM port muxing stay in ram_sp_arbiter.

Verification
REQ-019 The bench shall connect a 16x8 single-port sync-read RAM model and cover these directed scenarios:
  - Reset then idle: init_done rises 17 edges after rst falls. Every read of addresses 0..15 returns 00. req_ready stays 0 before init_done.
  - Requester 0 writes AA@1, then requester 1 writes FF@2. Reads of address 1 then address 2 return rsp_data AA then FF, each 2 edges after accept, on the requesting rsp_valid bit.
  - Both requesters hold req_valid continuously. Grants alternate 0,1,0,1 with zero idle cycles, and responses alternate in accept order.
  - Write 55@3 then a read of address 3 on the next cycle: read returns 55.
  - rst asserted the edge after a read accept: no rsp_valid appears, and the clear sweep restarts from address 0.
  - With RAM_ARB_WR_ACK_EN defined, a write of 3C@7 gives rsp_valid plus rsp_data=3C 2 edges after accept. With it undefined, no rsp_valid appears.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and default sizes for the single-port RAM arbiter.
// Holds the controller state encoding and RAM geometry defaults.
package ram_arb_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int N_REQ_DEF  = 2;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int RAM_DEPTH  = 1 << ADDR_W_DEF;

  function automatic int ram_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first valid requester at or after ptr_i,
// wrapping modulo N_REQ; grant_o is one-hot or zero.
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o
);

  logic found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!found && (j == (int'(ptr_i) + k) % N_REQ) && valid_i[j]) begin
          grant_o[j] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ram_sp_arbiter.sv
// Round-robin arbiter for N_REQ requesters onto one sync-read single-port RAM,
// with a post-reset clear sweep. RAM_ARB_WR_ACK_EN adds write acknowledges.
module ram_sp_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ-1:0]         req_we,
  input  logic [N_REQ*ADDR_W-1:0]  req_add,
  input  logic [N_REQ*DATA_W-1:0]  req_din,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [ADDR_W-1:0]        ram_add,
  output logic [DATA_W-1:0]        ram_din,
  output logic                     ram_wr_en,
  input  logic [DATA_W-1:0]        ram_dout,
  output logic                     init_done
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e              state_q;
  logic [ADDR_W:0]     cnt_q;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [ADDR_W-1:0]   last_add_q;
  logic                init_done_q;
  logic [N_REQ-1:0]    vld1_q;
  logic [N_REQ-1:0]    rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
`ifdef RAM_ARB_WR_ACK_EN
  logic                wr1_q;
  logic [DATA_W-1:0]   wdat1_q;
`endif

  logic [N_REQ-1:0]    grant;
  logic [PTR_W-1:0]    gidx;
  logic [ADDR_W-1:0]   sel_add;
  logic [DATA_W-1:0]   sel_din;
  logic                sel_we;
  logic                run;
  logic                accept;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  always_comb begin
    gidx    = '0;
    sel_add = '0;
    sel_din = '0;
    sel_we  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        gidx    = PTR_W'(i);
        sel_add = req_add[i*ADDR_W +: ADDR_W];
        sel_din = req_din[i*DATA_W +: DATA_W];
        sel_we  = req_we[i];
      end
    end
    run    = (state_q == ST_RUN);
    accept = run && (|grant);
    ptr_d  = (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
  end

  // The sweep runs one extra cycle with writes off after the last address,
  // so RUN starts on the edge after the final clear write.
  always_comb begin
    req_ready = run ? grant : '0;
    if (!run) begin
      ram_add   = cnt_q[ADDR_W-1:0];
      ram_din   = '0;
      ram_wr_en = ~cnt_q[ADDR_W];
    end else begin
      ram_add   = accept ? sel_add : last_add_q;
      ram_din   = sel_din;
      ram_wr_en = accept & sel_we;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign init_done = init_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      ptr_q       <= '0;
      last_add_q  <= '0;
      init_done_q <= 1'b0;
      vld1_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
`ifdef RAM_ARB_WR_ACK_EN
      wr1_q       <= 1'b0;
      wdat1_q     <= '0;
`endif
    end else begin
      rsp_valid_q <= vld1_q;
      vld1_q      <= '0;
`ifdef RAM_ARB_WR_ACK_EN
      if (|vld1_q) rsp_data_q <= wr1_q ? wdat1_q : ram_dout;
`else
      if (|vld1_q) rsp_data_q <= ram_dout;
`endif
      case (state_q)
        ST_INIT: begin
          if (cnt_q[ADDR_W]) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (accept) begin
            ptr_q      <= ptr_d;
            last_add_q <= sel_add;
`ifdef RAM_ARB_WR_ACK_EN
            vld1_q     <= grant;
            wr1_q      <= sel_we;
            wdat1_q    <= sel_din;
`else
            vld1_q     <= grant & ~req_we;
`endif
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Bench for ram_sp_arbiter with a 16x8 sync-read RAM and a transaction-level
// scoreboard (memory array + queue of expected responses keyed by due cycle).
module tb_ram_sp_arbiter;

`ifdef RAM_ARB_WR_ACK_EN
  localparam bit WR_ACK = 1'b1;
`else
  localparam bit WR_ACK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [7:0]  req_add;
  logic [15:0] req_din;
  logic [7:0]  rsp_data, ram_din, ram_dout;
  logic [3:0]  ram_add;
  logic        ram_wr_en, init_done;

  logic [7:0]  mem [16];

  always #5 clk = ~clk;

  ram_sp_arbiter #(.N_REQ(2), .ADDR_W(4), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_add   (req_add),
    .req_din   (req_din),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .ram_add   (ram_add),
    .ram_din   (ram_din),
    .ram_wr_en (ram_wr_en),
    .ram_dout  (ram_dout),
    .init_done (init_done)
  );

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_add] <= ram_din;
    ram_dout <= mem[ram_add];
  end

  typedef struct {
    int         idx;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mem_m [16];
  int         m_ptr;
  int         m_cyc;
  logic [3:0] m_last_add;
  int         checks;
  int         errors;

  task automatic model_reset();
    m_ptr      = 0;
    m_last_add = 4'h0;
    q.delete();
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
  endtask

  // One RUN-mode cycle: drive, check combinational outputs, clock, check responses.
  task automatic cycle(input logic [1:0] v, input logic [1:0] we,
                       input logic [7:0] add, input logic [15:0] din);
    int         g;
    logic [1:0] exp_rdy;
    logic [3:0] a;
    logic [7:0] d;
    exp_t       e;
    logic [1:0] exp_v;
    req_valid = v;
    req_we    = we;
    req_add   = add;
    req_din   = din;
    #2;
    g = -1;
    for (int k = 0; k < 2; k++)
      if (g < 0 && v[(m_ptr + k) % 2]) g = (m_ptr + k) % 2;
    exp_rdy = (g >= 0) ? (2'b01 << g) : 2'b00;
    checks++;
    if (req_ready !== exp_rdy) begin
      errors++;
      $display("FAIL ready: got %b expected %b", req_ready, exp_rdy);
    end
    a = (g >= 0) ? add[g*4 +: 4] : m_last_add;
    d = (g >= 0) ? din[g*8 +: 8] : 8'h00;
    checks++;
    if (ram_add !== a || ram_wr_en !== ((g >= 0) ? we[g] : 1'b0)) begin
      errors++;
      $display("FAIL ram_port: got add %h we %b expected add %h we %b", ram_add, ram_wr_en,
               a, (g >= 0) ? we[g] : 1'b0);
    end
    if (g >= 0 && we[g]) begin
      checks++;
      if (ram_din !== d) begin
        errors++;
        $display("FAIL ram_din: got %h expected %h", ram_din, d);
      end
    end
    @(posedge clk);
    m_cyc++;
    if (g >= 0) begin
      if (we[g]) begin
        mem_m[a] = d;
        if (WR_ACK) q.push_back('{idx: g, data: d, due: m_cyc + 1});
      end else begin
        q.push_back('{idx: g, data: mem_m[a], due: m_cyc + 1});
      end
      m_ptr      = (g + 1) % 2;
      m_last_add = a;
    end
    #1;
    exp_v = 2'b00;
    e     = '{idx: 0, data: 8'h00, due: 0};
    if (q.size() > 0 && q[0].due == m_cyc) begin
      e     = q.pop_front();
      exp_v = 2'b01 << e.idx;
    end
    checks++;
    if (rsp_valid !== exp_v) begin
      errors++;
      $display("FAIL rsp_valid: got %b expected %b", rsp_valid, exp_v);
    end
    if (exp_v != 2'b00) begin
      checks++;
      if (rsp_data !== e.data) begin
        errors++;
        $display("FAIL rsp_data: got %h expected %h", rsp_data, e.data);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(2'b00, 2'b00, 8'h00, 16'h0000);
  endtask

  // Release reset and follow the clear sweep until init_done.
  task automatic wait_init();
    int edges;
    edges     = 0;
    rst       = 1'b0;
    req_valid = 2'b11;
    req_we    = 2'b00;
    for (int k = 1; k <= 40; k++) begin
      #1;
      checks++;
      if (req_ready !== 2'b00) begin
        errors++;
        $display("FAIL init_ready: got %b expected 00", req_ready);
      end
      if (k <= 16) begin
        checks++;
        if (ram_add !== 4'(k - 1) || ram_wr_en !== 1'b1 || ram_din !== 8'h00) begin
          errors++;
          $display("FAIL sweep: got add %h we %b din %h expected add %h we 1 din 00",
                   ram_add, ram_wr_en, ram_din, 4'(k - 1));
        end
      end
      @(posedge clk);
      #1;
      if (init_done === 1'b1) begin
        edges = k;
        break;
      end
    end
    checks++;
    if (edges != 17) begin
      errors++;
      $display("FAIL init_edges: got %0d expected 17", edges);
    end
    model_reset();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 2'b11;
    req_we    = 2'b00;
    req_add   = 8'h00;
    req_din   = 16'h0000;
    for (int i = 0; i < 16; i++) mem[i] <= 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (init_done !== 1'b0 || rsp_valid !== 2'b00 || rsp_data !== 8'h00 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_outs: got done %b rv %b rd %h rdy %b expected 0 00 00 00",
               init_done, rsp_valid, rsp_data, req_ready);
    end
    checks++;
    if (ram_add !== 4'h0 || ram_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_ram: got add %h we %b expected 0 1", ram_add, ram_wr_en);
    end
    wait_init();
  endtask

  task automatic test_clear();
    for (int a = 0; a < 16; a++)
      cycle(2'b01 << (a % 2), 2'b00, {4'(a), 4'(a)}, 16'h0000);
    idle(2);
  endtask

  task automatic test_write_read();
    cycle(2'b01, 2'b01, 8'h01, 16'h00AA);
    cycle(2'b10, 2'b10, 8'h20, 16'hFF00);
    cycle(2'b01, 2'b00, 8'h01, 16'h0000);
    cycle(2'b10, 2'b00, 8'h20, 16'h0000);
    idle(2);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++)
      cycle(2'b11, 2'b00, 8'($urandom), 16'h0000);
    idle(2);
  endtask

  task automatic test_raw();
    cycle(2'b01, 2'b01, 8'h03, 16'h0055);
    cycle(2'b10, 2'b00, 8'h30, 16'h0000);
    idle(2);
  endtask

  task automatic test_wr_ack();
    cycle(2'b10, 2'b10, 8'h70, 16'h3C00);
    idle(2);
    cycle(2'b01, 2'b00, 8'h07, 16'h0000);
    idle(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++)
      cycle(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom), 16'($urandom));
    idle(2);
  endtask

  task automatic test_reset_inflight();
    cycle(2'b01, 2'b00, 8'h01, 16'h0000);
    rst       = 1'b1;
    req_valid = 2'b00;
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 2'b00 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL inflight_rst: got rv %b done %b expected 00 0", rsp_valid, init_done);
    end
    checks++;
    if (ram_add !== 4'h0 || ram_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL inflight_sweep: got add %h we %b expected 0 1", ram_add, ram_wr_en);
    end
    wait_init();
    idle(3);
    test_clear();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_cyc  = 0;
    model_reset();
    test_reset();
    test_clear();
    test_write_read();
    test_back_to_back();
    test_raw();
    test_wr_ack();
    test_random();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
